// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes emitted by ALU control and execute-stage states.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // True for codes that complete in a single cycle.
  function automatic logic is_simple(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the pipeline and the execute unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alucontrol, a, b,
    input  busy, done, result, zero, illegal, hi, lo
  );

  modport slave (
    input  start, alucontrol, a, b,
    output busy, done, result, zero, illegal, hi, lo
  );
endinterface

// File: rtl/alu_exec_unit_muldiv_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) / divide (restoring) datapath.
// nxt_hi/nxt_lo are the register values after the current step, so the final
// step's values can be captured by the parent on the same edge.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;   // partial product high half / partial remainder
  logic [WIDTH-1:0] q;     // multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0] m;     // multiplicand / divisor
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign last = (cnt == CW'(WIDTH - 1));

  // Compute the next {acc, q} for one iteration of the selected operation.
  // Divide uses a full-width compare rather than the borrow bit so that a zero
  // divisor naturally yields quotient all-ones and remainder equal to the dividend.
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    trial  = {acc, q[WIDTH-1]};
    diff   = trial - {1'b0, m};
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], q[WIDTH-1:1]};
    if (div_mode) begin
      if (trial >= {1'b0, m}) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {q[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Operand latch on load, one iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      q   <= '0;
      m   <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
      q   <= a;
      m   <= b;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      acc <= nxt_hi;
      q   <= nxt_lo;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arith ops plus iterative MULT/DIVU with HI/LO.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);
  state_t           state, state_nxt;
  logic             load, step, last;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH-1:0] simple_res;
  logic             simple_ok;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             zero_q, done_q, illegal_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .div_mode (state == DIV),
    .a        (bus.a),
    .b        (bus.b),
    .last     (last),
    .nxt_hi   (nxt_hi),
    .nxt_lo   (nxt_lo)
  );

  // Single-cycle operation results.
  always_comb begin
    simple_ok  = is_simple(bus.alucontrol);
    simple_res = '0;
    case (bus.alucontrol)
      ALU_AND: simple_res = bus.a & bus.b;
      ALU_OR:  simple_res = bus.a | bus.b;
      ALU_ADD: simple_res = bus.a + bus.b;
      ALU_SUB: simple_res = bus.a - bus.b;
      ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_NOR: simple_res = ~(bus.a | bus.b);
      default: simple_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.alucontrol == ALU_MULT) begin
          load      = 1'b1;
          state_nxt = MUL;
        end else if (bus.start && bus.alucontrol == ALU_DIVU) begin
          load      = 1'b1;
          state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: done/illegal pulse, result/zero/hi/lo hold between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (state == IDLE && bus.start && !load) begin
        result_q  <= simple_res;
        zero_q    <= (simple_res == '0);
        illegal_q <= !simple_ok;
        done_q    <= 1'b1;
      end
      if (step && last) begin
        hi_q     <= nxt_hi;
        lo_q     <= nxt_lo;
        result_q <= nxt_lo;
        zero_q   <= (nxt_lo == '0);
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule
